// File: rtl/updi_seq_pkg.sv
// updi_seq_pkg: shared op, state and UPDI field encodings for the op sequencer
package updi_seq_pkg;
  typedef enum logic [1:0] {OP_LDCS, OP_STCS, OP_LDS, OP_STS} op_t;
  typedef logic [2:0] seq_state_t;
  localparam seq_state_t S_IDLE     = 3'd0;
  localparam seq_state_t S_TX_START = 3'd1;
  localparam seq_state_t S_TX_BUSY  = 3'd2;
  localparam seq_state_t S_TX_DONE  = 3'd3;
  localparam seq_state_t S_RX_START = 3'd4;
  localparam seq_state_t S_RX_WAIT  = 3'd5;
  localparam seq_state_t S_RESP     = 3'd6;
  localparam logic [1:0] UPDI_SIZE_BYTE = 2'b00;
  localparam logic [1:0] UPDI_SIZE_WORD = 2'b01;
  localparam logic [2:0] INSN_LDS  = 3'b000;
  localparam logic [2:0] INSN_STS  = 3'b010;
  localparam logic [2:0] INSN_LDCS = 3'b100;
  localparam logic [2:0] INSN_STCS = 3'b110;
  function automatic logic [2:0] op_opcode(op_t op);
    return op == OP_LDS ? INSN_LDS : op == OP_STS ? INSN_STS : op == OP_LDCS ? INSN_LDCS : INSN_STCS;
  endfunction
endpackage

// File: rtl/updi_timeout_counter.sv
// updi_timeout_counter: per-state wait counter, saturates at its terminal count
module updi_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_tc
);
  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [W-1:0] TC = W'(TIMEOUT_CYCLES - 1);
  logic [W-1:0] r_cnt;
  assign o_tc = r_cnt == TC;
  always_ff @(posedge clk)
    if (rst || i_clear) r_cnt <= '0;
    else if (i_enable && !o_tc) r_cnt <= r_cnt + 1'b1;
endmodule

// File: rtl/updi_op_sequencer.sv
// updi_op_sequencer: turns one LDCS/STCS/LDS/STS request into updi_interface handshakes and one response
module updi_op_sequencer
  import updi_seq_pkg::*;
#(
  parameter int MAX_DATA_SIZE  = 16,
  parameter int DATA_ADDR_BITS = $clog2(MAX_DATA_SIZE),
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_req_valid,
  output logic                       o_req_ready,
  input  logic [1:0]                 i_req_op,
  input  logic [3:0]                 i_req_cs_addr,
  input  logic [15:0]                i_req_addr,
  input  logic [7:0]                 i_req_wdata,
  output logic                       o_rsp_valid,
  output logic [7:0]                 o_rsp_rdata,
  output logic                       o_rsp_error,
  output logic [2:0]                 o_instruction,
  output logic [1:0]                 o_size_a,
  output logic [1:0]                 o_size_b,
  output logic [1:0]                 o_ptr,
  output logic [3:0]                 o_cs_addr,
  output logic                       o_sib,
  output logic [1:0]                 o_size_c,
  output logic [8*MAX_DATA_SIZE-1:0] o_data,
  output logic [DATA_ADDR_BITS-1:0]  o_data_len,
  output logic [MAX_DATA_SIZE-1:0]   o_wait_ack_after,
  output logic                       o_tx_start,
  input  logic                       i_tx_ready,
  output logic                       o_rx_start,
  output logic [DATA_ADDR_BITS-1:0]  o_rx_n_bytes,
  input  logic                       i_rx_ready,
  input  logic                       i_ack_error,
  input  logic [7:0]                 i_rx_fifo_data,
  input  logic                       i_rx_fifo_wr_en,
  output logic                       o_rx_fifo_full
);
  seq_state_t r_state, w_next;
  op_t r_op, w_op;
  logic r_err, r_to, r_got, r_rx_fell;
  logic [7:0] r_rdata;
  logic w_tc, w_wait, w_accept, w_read, w_mem, w_adv, w_to, w_err;
  logic [8*MAX_DATA_SIZE-1:0] w_data;
  logic [DATA_ADDR_BITS-1:0] w_len;
  updi_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (r_state != w_next),
    .i_enable (w_wait),
    .o_tc     (w_tc)
  );
  assign w_op     = op_t'(i_req_op);
  assign w_mem    = w_op == OP_LDS || w_op == OP_STS;
  assign w_accept = r_state == S_IDLE && i_req_valid;
  assign w_read   = r_op == OP_LDCS || r_op == OP_LDS;
  assign w_wait   = r_state != S_IDLE && r_state != S_RESP;
  assign w_err    = r_err || r_to || (w_read && !r_got);
  // Each transfer only counts as done after its ready has fallen and risen again
  always_comb begin
    w_adv = r_state == S_IDLE     ? i_req_valid :
            r_state == S_TX_START ? i_tx_ready :
            r_state == S_TX_BUSY  ? !i_tx_ready :
            r_state == S_TX_DONE  ? i_tx_ready :
            r_state == S_RX_START ? i_rx_ready :
            r_state == S_RX_WAIT  ? r_rx_fell && i_rx_ready : 1'b1;
    w_to = w_wait && w_tc && !w_adv;
    w_next = w_to                  ? S_RESP :
             !w_adv                ? r_state :
             r_state == S_IDLE     ? S_TX_START :
             r_state == S_TX_START ? S_TX_BUSY :
             r_state == S_TX_BUSY  ? S_TX_DONE :
             r_state == S_TX_DONE  ? (w_read ? S_RX_START : S_RESP) :
             r_state == S_RX_START ? S_RX_WAIT :
             r_state == S_RX_WAIT  ? S_RESP : S_IDLE;
  end
  always_comb begin
    w_data = '0;
    w_data[7:0]   = w_op == OP_STCS ? i_req_wdata : w_mem ? i_req_addr[7:0] : 8'h00;
    w_data[15:8]  = w_mem ? i_req_addr[15:8] : 8'h00;
    w_data[23:16] = w_op == OP_STS ? i_req_wdata : 8'h00;
    w_len = DATA_ADDR_BITS'(w_op == OP_STS ? 3 : w_op == OP_LDS ? 2 : w_op == OP_STCS ? 1 : 0);
  end
  always_ff @(posedge clk)
    if (rst) begin
      r_state          <= S_IDLE;
      r_op             <= OP_LDCS;
      r_err            <= 1'b0;
      r_to             <= 1'b0;
      r_got            <= 1'b0;
      r_rx_fell        <= 1'b0;
      r_rdata          <= 8'h00;
      o_instruction    <= 3'b000;
      o_size_a         <= UPDI_SIZE_BYTE;
      o_cs_addr        <= 4'h0;
      o_data           <= '0;
      o_data_len       <= '0;
      o_wait_ack_after <= '0;
      o_rx_n_bytes     <= '0;
    end else begin
      r_state   <= w_next;
      r_rx_fell <= r_state == S_RX_WAIT && (r_rx_fell || !i_rx_ready);
      if (w_accept) begin
        r_op             <= w_op;
        r_err            <= 1'b0;
        r_to             <= 1'b0;
        r_got            <= 1'b0;
        r_rdata          <= 8'h00;
        o_instruction    <= op_opcode(w_op);
        o_size_a         <= w_mem ? UPDI_SIZE_WORD : UPDI_SIZE_BYTE;
        o_cs_addr        <= w_mem ? 4'h0 : i_req_cs_addr;
        o_data           <= w_data;
        o_data_len       <= w_len;
        o_wait_ack_after <= w_op == OP_STS ? MAX_DATA_SIZE'(6) : '0;
        o_rx_n_bytes     <= DATA_ADDR_BITS'(w_op == OP_LDCS || w_op == OP_LDS);
      end else begin
        if (w_wait && i_ack_error) r_err <= 1'b1;
        if (w_to) r_to <= 1'b1;
        if (r_state == S_RX_WAIT && i_rx_fifo_wr_en && !r_got) begin
          r_rdata <= i_rx_fifo_data;
          r_got   <= 1'b1;
        end
      end
    end
  assign o_req_ready    = r_state == S_IDLE;
  assign o_rsp_valid    = r_state == S_RESP;
  assign o_rsp_error    = o_rsp_valid && w_err;
  assign o_rsp_rdata    = (o_rsp_valid && !w_err) ? r_rdata : 8'h00;
  assign o_tx_start     = r_state == S_TX_START && i_tx_ready;
  assign o_rx_start     = r_state == S_RX_START && i_rx_ready;
  assign o_size_b       = UPDI_SIZE_BYTE;
  assign o_ptr          = 2'b00;
  assign o_sib          = 1'b0;
  assign o_size_c       = 2'b00;
  assign o_rx_fifo_full = 1'b0;
endmodule

// File: tb/tb_updi_op_sequencer.sv
// tb_updi_op_sequencer: table, corner-case and random requests against a behavioural interface and response model
module tb_updi_op_sequencer;
  import updi_seq_pkg::op_t;
  import updi_seq_pkg::OP_LDCS;
  import updi_seq_pkg::OP_STCS;
  import updi_seq_pkg::OP_LDS;
  import updi_seq_pkg::OP_STS;
  typedef struct {
    op_t op; logic [3:0] cs; logic [15:0] addr; logic [7:0] wd;
    int pre; int low; bit stuck; bit ack; int rxl; bit send; logic [7:0] rb; bit rst_rx;
  } req_t;
  typedef struct { req_t r; logic [7:0] rd; bit err; } vec_t;
  logic clk = 0, rst = 1;
  logic req_valid = 0, req_ready, rsp_valid, rsp_error, sib, tx_start, rx_start, fifo_full;
  logic tx_ready = 1, rx_ready = 1, ack_error = 0, wr_en = 0;
  logic [1:0] req_op = 0, size_a, size_b, ptr, size_c;
  logic [3:0] req_cs = 0, cs_addr, data_len, rx_n;
  logic [15:0] req_addr = 0, wack;
  logic [7:0] req_wdata = 0, rsp_rdata, fifo_data = 0;
  logic [2:0] instruction;
  logic [127:0] data;
  int n_vec = 0, n_err = 0;
  vec_t tbl[8];
  always #5 clk = ~clk;
  updi_op_sequencer #(.MAX_DATA_SIZE(16), .DATA_ADDR_BITS(4), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_op(req_op),
    .i_req_cs_addr(req_cs), .i_req_addr(req_addr), .i_req_wdata(req_wdata), .o_rsp_valid(rsp_valid),
    .o_rsp_rdata(rsp_rdata), .o_rsp_error(rsp_error), .o_instruction(instruction), .o_size_a(size_a),
    .o_size_b(size_b), .o_ptr(ptr), .o_cs_addr(cs_addr), .o_sib(sib), .o_size_c(size_c), .o_data(data),
    .o_data_len(data_len), .o_wait_ack_after(wack), .o_tx_start(tx_start), .i_tx_ready(tx_ready),
    .o_rx_start(rx_start), .o_rx_n_bytes(rx_n), .i_rx_ready(rx_ready), .i_ack_error(ack_error),
    .i_rx_fifo_data(fifo_data), .i_rx_fifo_wr_en(wr_en), .o_rx_fifo_full(fifo_full));
  task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  function automatic req_t mk(op_t op, logic [3:0] cs, logic [15:0] a, logic [7:0] wd, int pre, int low,
                              bit stuck, bit ack, int rxl, bit send, logic [7:0] rb, bit rr);
    req_t r;
    r.op = op; r.cs = cs; r.addr = a; r.wd = wd; r.pre = pre; r.low = low; r.stuck = stuck;
    r.ack = ack; r.rxl = rxl; r.send = send; r.rb = rb; r.rst_rx = rr;
    return r;
  endfunction
  function automatic vec_t mv(req_t r, logic [7:0] rd, bit e);
    vec_t v;
    v.r = r; v.rd = rd; v.err = e;
    return v;
  endfunction
  function automatic bit is_rd(op_t op);
    return op == OP_LDCS || op == OP_LDS;
  endfunction
  function automatic logic [2:0] exp_ins(op_t op);
    return op == OP_LDS ? 3'b000 : op == OP_STS ? 3'b010 : op == OP_LDCS ? 3'b100 : 3'b110;
  endfunction
  // Payload as the list of bytes the instruction carries after its opcode
  function automatic void model_pay(input req_t r, output logic [127:0] d, output int len, output logic [15:0] wa);
    logic [7:0] q[$];
    q = {};
    if (r.op == OP_STCS) q.push_back(r.wd);
    if (r.op == OP_LDS || r.op == OP_STS) begin q.push_back(r.addr[7:0]); q.push_back(r.addr[15:8]); end
    if (r.op == OP_STS) q.push_back(r.wd);
    d = '0;
    foreach (q[i]) d[8*i +: 8] = q[i];
    len = q.size();
    wa = r.op == OP_STS ? 16'h0006 : 16'h0000;
  endfunction
  function automatic void model_rsp(input req_t r, output logic [7:0] rd, output bit e);
    e = r.ack || r.stuck || (is_rd(r.op) && !r.send);
    rd = (is_rd(r.op) && !e) ? r.rb : 8'h00;
  endfunction
  task automatic run_req(input req_t r, input logic [7:0] e_rd, input bit e_err);
    int t_txs = -1, t_rxs = -1, t_rsp = -1, n_txs = 0, n_rxs = 0, n_rsp = 0, bad_rdy = 0, e_len;
    logic [7:0] rd = 0; bit er = 0;
    logic [2:0] ins = 0; logic [1:0] sa = 0; logic [6:0] misc = 0; logic [3:0] csa = 0, len = 0, rxn = 0;
    logic [127:0] dat = 0, e_dat; logic [15:0] wa = 0, e_wa;
    bit rdop = is_rd(r.op);
    model_pay(r, e_dat, e_len, e_wa);
    @(negedge clk);
    req_op = r.op; req_cs = r.cs; req_addr = r.addr; req_wdata = r.wd; req_valid = 1;
    tx_ready = !r.stuck && r.pre == 0; rx_ready = 1; ack_error = 0; wr_en = 0;
    #1 chk("idle_ready", req_ready, 1);
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      req_valid = 0;
      rst = r.rst_rx && t_rxs >= 0 && c == t_rxs + 2;
      tx_ready = r.stuck ? 0 : t_txs < 0 ? c > r.pre : !(c > t_txs && c <= t_txs + r.low);
      ack_error = r.ack && t_txs >= 0 && c == t_txs + 1;
      rx_ready = t_rxs < 0 ? 1 : !(c > t_rxs && c <= t_rxs + r.rxl);
      wr_en = 0; fifo_data = 8'h00;
      if (t_txs >= 0 && c == t_txs + 1) begin wr_en = 1; fifo_data = 8'hEE; end
      if (r.send && t_rxs >= 0 && c == t_rxs + 1) begin wr_en = 1; fifo_data = r.rb; end
      if (r.send && t_rxs >= 0 && r.rxl >= 2 && c == t_rxs + 2) begin wr_en = 1; fifo_data = ~r.rb; end
      #1;
      if (r.rst_rx && t_rxs >= 0 && c == t_rxs + 3) begin
        chk("rst_ready", req_ready, 1);
        chk("rst_len", data_len, 0);
      end
      if (tx_start) begin
        n_txs++;
        if (t_txs < 0) begin
          t_txs = c; ins = instruction; sa = size_a; misc = {size_b, ptr, sib, size_c};
          csa = cs_addr; dat = data; len = data_len; wa = wack;
        end
      end
      if (rx_start) begin n_rxs++; t_rxs = c; rxn = rx_n; end
      if (rsp_valid) begin n_rsp++; t_rsp = c; rd = rsp_rdata; er = rsp_error; end
      if (req_ready && n_rsp == 0 && !(r.rst_rx && t_rxs >= 0 && c >= t_rxs + 3)) bad_rdy++;
      if ((t_rsp >= 0 && c >= t_rsp + 2) || (r.rst_rx && t_rxs >= 0 && c >= t_rxs + 8)) break;
    end
    rst = 0;
    if (r.rst_rx) begin
      chk("rst_no_rsp", n_rsp, 0);
      chk("rst_rx_seen", n_rxs, 1);
    end else begin
      chk("rsp_count", n_rsp, 1);
      chk("rsp_rdata", rd, e_rd);
      chk("rsp_error", er, e_err);
      chk("early_ready", bad_rdy, 0);
      chk("tx_count", n_txs, r.stuck ? 0 : 1);
      chk("rx_count", n_rxs, (rdop && !r.stuck) ? 1 : 0);
      chk("end_ready", req_ready, 1);
      if (r.stuck) chk("timeout_lat", t_rsp >= 16 && t_rsp <= 18, 1);
      else begin
        chk("tx_lat", t_txs, r.pre + 1);
        chk("rsp_lat", t_rsp, rdop ? t_rxs + r.rxl + 2 : t_txs + r.low + 2);
        chk("instr", ins, exp_ins(r.op));
        chk("fixed_fields", misc, 0);
        chk("data", dat, e_dat);
        chk("data_len", len, e_len);
        chk("wait_ack", wa, e_wa);
        if (r.op == OP_LDS || r.op == OP_STS) chk("size_a", sa, 2'b01);
        else chk("cs_addr", csa, r.cs);
        if (rdop) chk("rx_n", rxn, 1);
      end
    end
  endtask
  initial begin
    tbl[0] = mv(mk(OP_STS,  4'h0, 16'h1000, 8'h55, 0, 3, 0, 0, 1, 0, 8'h00, 0), 8'h00, 0);
    tbl[1] = mv(mk(OP_LDCS, 4'h0, 16'h0000, 8'h00, 0, 2, 0, 0, 3, 1, 8'h30, 0), 8'h30, 0);
    tbl[2] = mv(mk(OP_LDS,  4'h0, 16'h1F00, 8'h00, 0, 2, 0, 1, 2, 1, 8'hAA, 0), 8'h00, 1);
    tbl[3] = mv(mk(OP_STCS, 4'h2, 16'h0000, 8'h5A, 0, 1, 1, 0, 1, 0, 8'h00, 0), 8'h00, 1);
    tbl[4] = mv(mk(OP_LDS,  4'h0, 16'h2345, 8'h00, 0, 1, 0, 0, 1, 0, 8'h77, 0), 8'h00, 1);
    tbl[5] = mv(mk(OP_LDCS, 4'hB, 16'h0000, 8'h00, 4, 1, 0, 0, 4, 1, 8'hA5, 0), 8'hA5, 0);
    tbl[6] = mv(mk(OP_STCS, 4'h3, 16'h0000, 8'hC3, 2, 1, 0, 0, 1, 0, 8'h00, 0), 8'h00, 0);
    tbl[7] = mv(mk(OP_LDS,  4'h0, 16'h00FF, 8'h00, 1, 5, 0, 0, 2, 1, 8'h5C, 0), 8'h5C, 0);
    req_valid = 1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_error", rsp_error, 0);
    chk("rst_starts", {tx_start, rx_start, fifo_full}, 0);
    chk("rst_payload", {instruction, cs_addr, data_len, wack, rx_n}, 0);
    chk("rst_data", data, 0);
    @(negedge clk);
    rst = 0; req_valid = 0;
    foreach (tbl[i]) run_req(tbl[i].r, tbl[i].rd, tbl[i].err);
    run_req(mk(OP_LDS, 4'h0, 16'h4242, 8'h00, 0, 2, 0, 0, 6, 1, 8'h99, 1), 8'h00, 0);
    run_req(mk(OP_STCS, 4'h1, 16'h0000, 8'h3C, 0, 2, 0, 0, 1, 0, 8'h00, 0), 8'h00, 0);
    begin : b2b
      int k = 0, nr = 0, tlo = 0, last_rsp = -10, bad = 0;
      for (int c = 1; c <= 200; c++) begin
        @(negedge clk);
        req_valid = k < 4; req_op = OP_STCS; req_wdata = 8'h10 + 8'(k); req_cs = 4'h5;
        tx_ready = tlo == 0; rx_ready = 1; ack_error = 0; wr_en = 0;
        if (tlo > 0) tlo--;
        #1;
        if (tx_start) begin chk("b2b_wdata", data[7:0], 8'h10 + 8'(k - 1)); tlo = 2; end
        if (rsp_valid) begin nr++; last_rsp = c; if (req_ready || rsp_error) bad++; end
        if (req_valid && req_ready) begin
          if (k > 0 && c != last_rsp + 1) bad++;
          if (nr != k) bad++;
          k++;
        end
        if (k == 4 && nr == 4) break;
      end
      req_valid = 0;
      chk("b2b_accepts", k, 4);
      chk("b2b_rsps", nr, 4);
      chk("b2b_order", bad, 0);
    end
    for (int i = 0; i < 40; i++) begin
      req_t r; logic [7:0] rd; bit e;
      r = mk(op_t'($urandom_range(0, 3)), 4'($urandom), 16'($urandom), 8'($urandom),
             $urandom_range(0, 4), $urandom_range(1, 6), 0, $urandom_range(0, 3) == 0,
             $urandom_range(1, 6), $urandom_range(0, 4) != 0, 8'($urandom), 0);
      model_rsp(r, rd, e);
      run_req(r, rd, e);
    end
    chk("fifo_full", fifo_full, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
